// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks in-flight producers, selects forwarding sources, stalls on unready loads, counts stalls.
//   Ports: clk, rst (sync, active-high); issue_* describe the instruction entering EXE; flush kills
//   in-flight producers; stall holds issue; fwd_{a,b}_{hit,stage,class} give the youngest matching
//   producer per operand; stall_cycles/stall_events are saturating performance counters.
module hazard_scoreboard #(
  parameter int DEPTH    = 2,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic [4:0]       issue_rs1,
  input  logic [4:0]       issue_rs2,
  input  logic             issue_rs1_used,
  input  logic             issue_rs2_used,
  input  logic [4:0]       issue_rd,
  input  logic             issue_wb,
  input  logic [1:0]       issue_class,
  input  logic             flush,
  output logic             stall,
  output logic             fwd_a_hit,
  output logic             fwd_b_hit,
  output logic [2:0]       fwd_a_stage,
  output logic [2:0]       fwd_b_stage,
  output logic [1:0]       fwd_a_class,
  output logic [1:0]       fwd_b_class,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] stall_events
);
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [CNT_W-1:0] ONE = 1;
  typedef enum logic {RUN, STALL} state_t;
  state_t state_q;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [4:0] rd_q [DEPTH];
  logic [4:0] rd_d [DEPTH];
  logic [1:0] cls_q [DEPTH];
  logic [1:0] cls_d [DEPTH];
  logic [CNT_W-1:0] cyc_q, evt_q;
  logic a_rdy, b_rdy;
  // Scan oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    fwd_a_hit = 1'b0;
    fwd_a_stage = '0;
    fwd_a_class = '0;
    a_rdy = 1'b1;
    fwd_b_hit = 1'b0;
    fwd_b_stage = '0;
    fwd_b_class = '0;
    b_rdy = 1'b1;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (valid_q[i] && issue_valid && issue_rs1_used && issue_rs1 != 5'd0 && rd_q[i] == issue_rs1) begin
        fwd_a_hit = 1'b1;
        fwd_a_stage = 3'(i + 1);
        fwd_a_class = cls_q[i];
        a_rdy = cls_q[i] != LOAD || i + 1 > LOAD_LAT;
      end
      if (valid_q[i] && issue_valid && issue_rs2_used && issue_rs2 != 5'd0 && rd_q[i] == issue_rs2) begin
        fwd_b_hit = 1'b1;
        fwd_b_stage = 3'(i + 1);
        fwd_b_class = cls_q[i];
        b_rdy = cls_q[i] != LOAD || i + 1 > LOAD_LAT;
      end
    end
  end
  assign stall = (fwd_a_hit & ~a_rdy) | (fwd_b_hit & ~b_rdy);
  // Older entries always advance; a stalled issue enters as a bubble.
  always_comb begin
    valid_d = '0;
    rd_d = rd_q;
    cls_d = cls_q;
    for (int i = DEPTH - 1; i > 0; i--) begin
      valid_d[i] = valid_q[i-1];
      rd_d[i] = rd_q[i-1];
      cls_d[i] = cls_q[i-1];
    end
    valid_d[0] = ~stall & issue_valid & issue_wb & (issue_rd != 5'd0);
    rd_d[0] = issue_rd;
    cls_d[0] = issue_class;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      state_q <= RUN;
      cyc_q <= '0;
      evt_q <= '0;
    end else begin
      valid_q <= flush ? '0 : valid_d;
      rd_q <= rd_d;
      cls_q <= cls_d;
      state_q <= (stall && !flush) ? STALL : RUN;
      cyc_q <= cyc_q + ((stall && cyc_q != '1) ? ONE : '0);
      evt_q <= evt_q + ((stall && state_q == RUN && evt_q != '1) ? ONE : '0);
    end
  end
  assign stall_cycles = cyc_q;
  assign stall_events = evt_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed checks of forwarding, load stalls, flush, counters and reset.
module tb_hazard_scoreboard;
  logic clk = 1'b0;
  logic rst, iv, u1, u2, wb, fl;
  logic [4:0] r1, r2, rd;
  logic [1:0] cl;
  logic st, ah, bh;
  logic [2:0] as, bs;
  logic [1:0] ac, bc;
  logic [15:0] cyc, evt;
  logic s_st, s_ah, s_bh;
  logic [2:0] s_as, s_bs;
  logic [1:0] s_ac, s_bc;
  logic [3:0] s_cyc, s_evt;
  logic z_st, z_ah, z_bh;
  logic [2:0] z_as, z_bs;
  logic [1:0] z_ac, z_bc;
  logic [15:0] z_cyc, z_evt;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  hazard_scoreboard dut (
    .clk(clk), .rst(rst), .issue_valid(iv), .issue_rs1(r1), .issue_rs2(r2),
    .issue_rs1_used(u1), .issue_rs2_used(u2), .issue_rd(rd), .issue_wb(wb),
    .issue_class(cl), .flush(fl), .stall(st), .fwd_a_hit(ah), .fwd_b_hit(bh),
    .fwd_a_stage(as), .fwd_b_stage(bs), .fwd_a_class(ac), .fwd_b_class(bc),
    .stall_cycles(cyc), .stall_events(evt)
  );
  hazard_scoreboard #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .issue_valid(iv), .issue_rs1(r1), .issue_rs2(r2),
    .issue_rs1_used(u1), .issue_rs2_used(u2), .issue_rd(rd), .issue_wb(wb),
    .issue_class(cl), .flush(fl), .stall(s_st), .fwd_a_hit(s_ah), .fwd_b_hit(s_bh),
    .fwd_a_stage(s_as), .fwd_b_stage(s_bs), .fwd_a_class(s_ac), .fwd_b_class(s_bc),
    .stall_cycles(s_cyc), .stall_events(s_evt)
  );
  hazard_scoreboard #(.LOAD_LAT(0)) dut_ll0 (
    .clk(clk), .rst(rst), .issue_valid(iv), .issue_rs1(r1), .issue_rs2(r2),
    .issue_rs1_used(u1), .issue_rs2_used(u2), .issue_rd(rd), .issue_wb(wb),
    .issue_class(cl), .flush(fl), .stall(z_st), .fwd_a_hit(z_ah), .fwd_b_hit(z_bh),
    .fwd_a_stage(z_as), .fwd_b_stage(z_bs), .fwd_a_class(z_ac), .fwd_b_class(z_bc),
    .stall_cycles(z_cyc), .stall_events(z_evt)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic drv(input logic v, input logic [4:0] a, input logic ua, input logic [4:0] b,
                     input logic ub, input logic [4:0] d, input logic w, input logic [1:0] c);
    iv = v; r1 = a; u1 = ua; r2 = b; u2 = ub; rd = d; wb = w; cl = c;
  endtask
  initial begin
    rst = 1'b1;
    fl = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_stall", st, 0);
    chk("rst_ahit", ah, 0);
    chk("rst_bhit", bh, 0);
    chk("rst_astage", as, 0);
    chk("rst_bstage", bs, 0);
    chk("rst_aclass", ac, 0);
    chk("rst_bclass", bc, 0);
    chk("rst_cyc", cyc, 0);
    chk("rst_evt", evt, 0);
    @(negedge clk); drv(1, 0, 0, 0, 0, 5, 1, 0);
    @(negedge clk); drv(1, 5, 1, 0, 0, 0, 0, 0);
    #1;
    chk("alu_ahit", ah, 1);
    chk("alu_astage", as, 1);
    chk("alu_aclass", ac, 0);
    chk("alu_stall", st, 0);
    chk("alu_bhit", bh, 0);
    @(negedge clk); drv(1, 0, 0, 0, 0, 6, 1, 1);
    @(negedge clk); drv(1, 0, 0, 6, 1, 9, 1, 0);
    #1;
    chk("ld_stall", st, 1);
    chk("ld_bhit", bh, 1);
    chk("ld_bstage1", bs, 1);
    chk("ld_bclass1", bc, 1);
    chk("ll0_nostall", z_st, 0);
    @(negedge clk);
    #1;
    chk("ld_stall_end", st, 0);
    chk("ld_bstage2", bs, 2);
    chk("ld_bclass2", bc, 1);
    chk("ld_evt", evt, 1);
    chk("ld_cyc", cyc, 1);
    @(negedge clk); drv(1, 0, 0, 0, 0, 0, 1, 0);
    #1;
    chk("ld_cyc_hold", cyc, 1);
    chk("x0w_stall", st, 0);
    @(negedge clk); drv(1, 0, 1, 9, 0, 0, 0, 0);
    #1;
    chk("x0_ahit", ah, 0);
    chk("unused_bhit", bh, 0);
    chk("unused_bstage", bs, 0);
    chk("x0_stall", st, 0);
    @(negedge clk); drv(1, 0, 0, 0, 0, 7, 1, 1);
    @(negedge clk); drv(1, 0, 0, 0, 0, 7, 1, 2);
    @(negedge clk); drv(1, 7, 1, 0, 0, 0, 0, 0);
    #1;
    chk("lui_ahit", ah, 1);
    chk("lui_astage", as, 1);
    chk("lui_aclass", ac, 2);
    chk("lui_stall", st, 0);
    @(negedge clk); drv(1, 0, 0, 0, 0, 8, 1, 1);
    @(negedge clk); drv(1, 8, 1, 0, 0, 10, 1, 0); fl = 1'b1;
    #1;
    chk("fl_stall", st, 1);
    chk("fl_astage", as, 1);
    @(negedge clk); fl = 1'b0;
    #1;
    chk("fl_after_stall", st, 0);
    chk("fl_after_ahit", ah, 0);
    chk("fl_after_bhit", bh, 0);
    chk("fl_evt", evt, 2);
    chk("fl_cyc", cyc, 2);
    for (int k = 0; k < 19; k++) begin
      @(negedge clk); drv(1, 0, 0, 0, 0, 6, 1, 1);
      @(negedge clk); drv(1, 6, 1, 0, 0, 0, 0, 0);
      #1;
      chk("sat_stall", st, 1);
      chk("sat_ll0", z_st, 0);
    end
    @(negedge clk); drv(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("main_cyc21", cyc, 21);
    chk("main_evt21", evt, 21);
    chk("sat_cyc", s_cyc, 15);
    chk("sat_evt", s_evt, 15);
    @(negedge clk); drv(1, 0, 0, 0, 0, 6, 1, 1);
    @(negedge clk); drv(1, 0, 0, 6, 1, 0, 0, 0); rst = 1'b1;
    #1;
    chk("mid_stall", st, 1);
    @(negedge clk); rst = 1'b0;
    #1;
    chk("post_rst_stall", st, 0);
    chk("post_rst_bhit", bh, 0);
    chk("post_rst_cyc", cyc, 0);
    chk("post_rst_evt", evt, 0);
    chk("post_rst_sat_cyc", s_cyc, 0);
    chk("post_rst_sat_evt", s_evt, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter DEPTH, default 2: number of tracked in-flight producer stages downstream of issue; legal range 1..7.
REQ-002 SHALL have parameter LOAD_LAT, default 1: stages a load must advance before its data is forwardable; legal range 0..DEPTH-1.
REQ-003 SHALL have parameter CNT_W, default 16: width of the performance counters.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 issue_valid  in  1  instruction present at issue (EXE entry).
REQ-007 issue_rs1, issue_rs2  in  5 each  source register addresses.
REQ-008 issue_rs1_used, issue_rs2_used  in  1 each  operand actually read (predecoded; LUI/AUIPC/JAL clear both; I-type, JALR and CSR-imm clear rs2; CSR-imm also clears rs1).
REQ-009 issue_rd  in  5  destination register address.
REQ-010 issue_wb  in  1  instruction writes rd.
REQ-011 issue_class  in  2  result source: 0 ALU, 1 LOAD, 2 IMM (LUI), 3 LINK (PC+4).
REQ-012 flush  in  1  kill all in-flight producers (branch/jump redirect).
REQ-013 stall  out  1  hold issue; a bubble is inserted downstream.
REQ-014 fwd_a_hit, fwd_b_hit  out  1 each  operand forwarded from the pipeline.
REQ-015 fwd_a_stage, fwd_b_stage  out  3 each  stage index 1..DEPTH supplying the operand; 0 when no hit.
REQ-016 fwd_a_class, fwd_b_class  out  2 each  issue_class of the supplying entry; 0 when no hit.
REQ-017 stall_cycles, stall_events  out  CNT_W each  performance counters.

Function
REQ-018 SHALL keep a DEPTH-entry shift register; each entry holds {valid, rd, class}; entry 1 is the youngest, entry DEPTH the oldest.
REQ-019 Each cycle without stall or flush, SHALL shift entries one stage older, drop entry DEPTH, and load entry 1 with {issue_valid & issue_wb & (issue_rd!=0), issue_rd, issue_class}.
REQ-020 In a stall cycle (no flush), SHALL still shift older entries but load entry 1 with valid=0 (bubble).
REQ-021 Entry s matches operand X when: valid, rd==issue_rsX, issue_rsX_used=1, issue_valid=1; x0 never matches.
REQ-022 When several entries match, SHALL select the lowest stage index (youngest producer).
REQ-023 Entry s is ready when class!=LOAD or s>LOAD_LAT.
REQ-024 stall SHALL be combinational and assert when the selected match for rs1 or rs2 is not ready; all other cases give stall=0.
REQ-025 fwd_X_* SHALL report the selected match whenever one exists, including during stall.
REQ-026 SHALL implement FSM RUN/STALL, registered, updated each cycle:
 - RUN->STALL when stall=1, and stall_events increments;
 - STALL->STALL while stall=1;
 - STALL->RUN when stall=0.
REQ-027 stall_cycles SHALL increment in every cycle where stall=1; both counters saturate at all-ones and never wrap.
REQ-028 flush SHALL have priority over stall and shift: next cycle all entries are invalid, FSM is RUN, and the issuing instruction is not recorded; counters are unaffected except for stall accounting in the flush cycle itself.
REQ-029 With LOAD_LAT=0, stall SHALL never assert.
REQ-030 Forwarding outputs SHALL have no registered latency: they reflect the current entries and the current issue inputs in the same cycle.

Reset
REQ-031 On rst=1 at a clock edge, SHALL clear all entry valid bits, set the FSM to RUN, and clear both counters; rst overrides flush and stall.
REQ-032 In the cycle after reset, and until a producer is recorded: stall=0, all fwd_* outputs 0.
REQ-033 rst asserted mid-stall SHALL drop the pending hazard; the next cycle has stall=0.

Verification (DEPTH=2, LOAD_LAT=1)
REQ-034 ALU rd=x5, then next cycle rs1=x5 used -> fwd_a_hit=1, stage=1, class=0, stall=0.
REQ-035 LOAD rd=x6, then rs2=x6 used -> stall=1 for exactly 1 cycle, stall_events=1, stall_cycles=1; next cycle fwd_b_stage=2, class=1, stall=0.
REQ-036 ALU rd=x0, then rs1=x0 -> fwd_a_hit=0; and I-type with rs2 field equal to the pending rd (rs2_used=0) -> fwd_b_hit=0.
REQ-037 LOAD rd=x7, then LUI rd=x7, then rs1=x7 -> stage=1, class=2, stall=0.
REQ-038 LOAD rd=x8, then dependent op stalls, then flush in the stall cycle -> next cycle stall=0, all hits 0, FSM RUN.
REQ-039 Force 2^CNT_W+3 stall cycles -> stall_cycles holds all-ones; rst -> counters 0 next cycle.
